load_store_unit: RTL and testbench

// - Drives the register-file write port (write_reg/write_data/reg_write) for loads; initiator toward data memory.
// - Accepts one load/store request from the core (valid/ready) and issues it on a req/ack memory handshake.
// - Performs byte-lane steering for stores and sign/zero extension for loads.
// - One access in flight; ends with a one-cycle done pulse and, for loads, a one-cycle register write.

---
 rtl/load_store_unit.sv | 209 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Takes one load/store request from the core and runs it as a single
//   req/ack transaction toward data memory. Stores get their bytes steered
//   onto the correct lanes. Loads get their byte or halfword extracted and
//   then sign- or zero-extended. Every access finishes with exactly one
//   one-cycle pulse: done for a normal completion, or err for a failed access.
//   A load with rd != 0 also produces a one-cycle register-file write.
//
// Configuration:
//   MISALIGN_TRAP_EN (define) - when defined, a misaligned H or W access goes
//     to ERR without touching memory. When undefined, the misaligned low
//     address bits are ignored and the access proceeds normally.
//   TIMEOUT_CYCLES (parameter) - the maximum number of cycles mem_req may wait
//     for mem_ack. 0 disables the timeout.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   req_valid / req_ready       core request handshake (ready only in IDLE)
//   req_is_store, req_funct3    access type and RV32I width/sign encoding
//   req_addr, req_wdata, req_rd byte address, low-aligned store data, load dest
//   mem_req/we/addr/wdata/be    memory request; held stable until mem_ack
//   mem_ack, mem_rdata          memory completion and read word
//   write_reg/write_data        register-file write index and value
//   reg_write                   register-file write enable
//   done, err                   one-cycle completion and failure pulses
//
// Handshakes:
//   - Core side: a request transfers on a rising edge where both req_valid
//     and req_ready are 1.
//   - Memory side: mem_req rises with mem_we/addr/wdata/be already valid, and
//     all of them stay stable until a rising edge where mem_ack is 1.
//     mem_ack is ignored whenever mem_req is 0.
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        reg_write,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t      state;
  logic        lat_is_store;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_lane;
  logic [4:0]  lat_rd;
  logic [31:0] timeout_cnt;

  // Decode of the incoming request: legality, byte enables, steered data.
  logic        req_illegal;
  logic [3:0]  req_be;
  logic [31:0] req_steered;

  always_comb begin
    req_illegal = 1'b0;
    req_be      = 4'hF;
    req_steered = req_wdata;
    case (req_funct3)
      3'b000, 3'b100: begin
        req_be      = 4'b0001 << req_addr[1:0];
        req_steered = {4{req_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        req_be      = 4'b0011 << {req_addr[1], 1'b0};
        req_steered = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        req_be      = 4'hF;
        req_steered = req_wdata;
      end
      default: req_illegal = 1'b1;
    endcase
    // Unsigned widths exist only for loads.
    if (req_is_store && req_funct3[2])
      req_illegal = 1'b1;
`ifdef MISALIGN_TRAP_EN
    if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00))
      req_illegal = 1'b1;
`endif
  end

  // Pick the addressed lane out of the read word and extend it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic [31:0] shifted;
    logic [15:0] half;
    shifted = word >> {lane, 3'b000};
    half    = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extend_load = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  extend_load = {24'h0, shifted[7:0]};
      3'b001:  extend_load = {{16{half[15]}}, half};
      3'b101:  extend_load = {16'h0, half};
      default: extend_load = word;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      mem_be       <= 4'h0;
      write_reg    <= 5'h0;
      write_data   <= 32'h0;
      reg_write    <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      lat_is_store <= 1'b0;
      lat_funct3   <= 3'h0;
      lat_lane     <= 2'h0;
      lat_rd       <= 5'h0;
      timeout_cnt  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_is_store <= req_is_store;
            lat_funct3   <= req_funct3;
            lat_lane     <= req_addr[1:0];
            lat_rd       <= req_rd;
            req_ready    <= 1'b0;
            timeout_cnt  <= 32'h0;
            if (req_illegal) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= req_is_store;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= req_be;
              mem_wdata <= req_steered;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            state   <= WB;
            mem_req <= 1'b0;
            done    <= 1'b1;
            if (!lat_is_store && lat_rd != 5'd0) begin
              reg_write  <= 1'b1;
              write_reg  <= lat_rd;
              write_data <= extend_load(lat_funct3, lat_lane, mem_rdata);
            end
          end else if (TIMEOUT_CYCLES != 0 &&
                       timeout_cnt == TIMEOUT_CYCLES - 32'd1) begin
            // This was the last allowed cycle of waiting.
            state   <= ERR;
            mem_req <= 1'b0;
            err     <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + 32'd1;
          end
        end
        WB: begin
          state     <= IDLE;
          done      <= 1'b0;
          reg_write <= 1'b0;
          req_ready <= 1'b1;
        end
        ERR: begin
          state     <= IDLE;
          err       <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Runs directed accesses taken from the block's intended behaviour, followed
// by a batch of random accesses. Each access is checked against a reference
// model that works from access width and byte offset using plain arithmetic.
// Expected load results wait in exp_q until the write-back cycle is checked.
// The timeout is set to 4 cycles here.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic        done;
  logic        err;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .done(done), .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_ok(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || (!st && (f3 == 3'd4 || f3 == 3'd5)));
`ifdef MISALIGN_TRAP_EN
    if (ok && (a % size_of(f3)) != 0) ok = 1'b0;
`endif
    return ok;
  endfunction

  // Byte offset of the accessed item inside the word (misaligned bits dropped).
  function automatic int offset_of(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = size_of(f3);
    return ((a % 4) / n) * n;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = size_of(f3);
    return 4'(((1 << n) - 1) << offset_of(f3, a));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (size_of(f3))
      1:       return (d & 32'hFF) * 32'h01010101;
      2:       return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    int n;
    logic [31:0] mask, v;
    n = size_of(f3);
    if (n == 4) return w;
    mask = (32'h1 << (8 * n)) - 32'h1;
    v = (w >> (8 * offset_of(f3, a))) & mask;
    if (f3 < 3'd4 && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [4:0] rd);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      step();
      guard++;
    end
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = d; req_rd = rd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [4:0] rd, input int dly,
                           input logic [31:0] rword);
    bit wr;
    drive_req(st, f3, a, d, rd);
    if (!model_ok(st, f3, a)) begin
      check("err_pulse", 32'(err), 32'd1);
      check("err_no_memreq", 32'(mem_req), 32'd0);
      check("err_no_done", 32'(done), 32'd0);
      check("err_no_regwrite", 32'(reg_write), 32'd0);
      step();
      check("err_end", 32'(err), 32'd0);
      check("err_ready", 32'(req_ready), 32'd1);
      check("err_still_no_memreq", 32'(mem_req), 32'd0);
      return;
    end
    wr = !st && rd != 5'd0;
    if (wr) exp_q.push_back(model_load(f3, a, rword));
    check("busy_not_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k <= dly; k++) begin
      check("mem_req", 32'(mem_req), 32'd1);
      check("mem_we", 32'(mem_we), 32'(st));
      check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
      check("mem_be", 32'(mem_be), 32'(model_be(f3, a)));
      if (st) check("mem_wdata", mem_wdata, model_wdata(f3, d));
      check("no_early_done", 32'(done), 32'd0);
      if (k == dly) begin
        mem_ack = 1'b1;
        mem_rdata = rword;
      end
      step();
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end
    check("wb_done", 32'(done), 32'd1);
    check("wb_memreq_low", 32'(mem_req), 32'd0);
    check("wb_no_err", 32'(err), 32'd0);
    check("wb_reg_write", 32'(reg_write), 32'(wr));
    if (wr) begin
      check("wb_write_reg", 32'(write_reg), 32'(rd));
      if (exp_q.size() > 0) check("wb_write_data", write_data, exp_q.pop_front());
      else check("scoreboard_empty", 32'd1, 32'd0);
    end
    step();
    check("post_done", 32'(done), 32'd0);
    check("post_reg_write", 32'(reg_write), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    do_reset();

    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_write_data", write_data, 32'h0);
    check("rst_write_reg", 32'(write_reg), 32'h0);

    // Directed accesses.
    do_access(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF);  // LW
    do_access(1'b0, 3'b000, 32'h103, 32'h0, 5'd3, 0, 32'h80FFFFFF);  // LB
    do_access(1'b0, 3'b100, 32'h103, 32'h0, 5'd3, 1, 32'h80FFFFFF);  // LBU
    do_access(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 5'd0, 3, 32'h0);  // SH
    do_access(1'b0, 3'b010, 32'h200, 32'h0, 5'd0, 0, 32'h12345678);  // LW rd=0
    do_access(1'b0, 3'b011, 32'h200, 32'h0, 5'd7, 0, 32'h0);         // illegal
    do_access(1'b1, 3'b101, 32'h200, 32'h0, 5'd7, 0, 32'h0);         // SHU illegal
    do_access(1'b0, 3'b010, 32'h101, 32'h0, 5'd9, 0, 32'hCAFEF00D);  // misaligned LW
    do_access(1'b0, 3'b101, 32'h103, 32'h0, 5'd9, 2, 32'h89AB0000);  // misaligned LHU
    do_access(1'b1, 3'b000, 32'h301, 32'h000000A5, 5'd0, 0, 32'h0);  // SB lane 1

    // Timeout: no ack, so err should pulse after TMO cycles in REQ.
    drive_req(1'b0, 3'b010, 32'h400, 32'h0, 5'd4);
    for (int k = 0; k < int'(TMO); k++) begin
      check("tmo_mem_req", 32'(mem_req), 32'd1);
      check("tmo_no_err_yet", 32'(err), 32'd0);
      step();
    end
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_mem_req_low", 32'(mem_req), 32'd0);
    check("tmo_no_done", 32'(done), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h11111111;  // late ack
    step();
    mem_ack = 1'b0;
    check("tmo_idle_ready", 32'(req_ready), 32'd1);
    check("late_ack_no_done", 32'(done), 32'd0);
    check("late_ack_no_regwrite", 32'(reg_write), 32'd0);
    check("late_ack_no_memreq", 32'(mem_req), 32'd0);

    // Reset while waiting in REQ.
    drive_req(1'b0, 3'b010, 32'h500, 32'h0, 5'd6);
    check("rst_mid_memreq_high", 32'(mem_req), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_memreq_low", 32'(mem_req), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("rst_mid_no_done", 32'(done), 32'd0);
    check("rst_mid_no_regwrite", 32'(reg_write), 32'd0);

    // Random accesses; ack delay stays below the timeout.
    for (int i = 0; i < 200; i++) begin
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, int'(TMO) - 1),
                $urandom);
      if ($urandom_range(0, 3) == 0) step();
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so a stuck run still terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
